pq_sort_host: RTL and testbench

- Host-side initiator for the priority-queue device interface: drives enq/deq/kvi and consumes kvo/full/empty/busy.
- Accepts a batch of key-value pairs on a valid/ready input stream and enqueues each one into an attached PQ.
- On the last input beat it drains the PQ and emits the pairs in priority order on a valid/ready output stream.
- Serves as the reusable front end for sort engines and as the traffic source in PQ benches; it works with any PQ implementation, busy or single-cycle.

---
 rtl/pq_pkg.sv | 10 +
 rtl/pq_sort_host.sv | 80 ++++++++
 tb/tb_pq_sort_host.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/pq_pkg.sv
// pq_pkg: shared priority-queue sizing and the key-value pair type
package pq_pkg;
   localparam int PQ_CAPACITY = 8;
   localparam int KEY_W = 8;
   localparam int VAL_W = 8;
   typedef struct packed {
      logic [KEY_W-1:0] key;
      logic [VAL_W-1:0] val;
   } kv_t;
endpackage

// File: rtl/pq_sort_host.sv
// pq_sort_host: fills an attached PQ from an input batch, then drains it in priority order
// Ports: clk/rst (sync, active-low); s_* input pair stream; m_* sorted output stream;
// pq_* command/status link to the PQ; batch_cnt items in batch; ovf/err sticky flags.
module pq_sort_host #(
   parameter int PQ_CAPACITY = pq_pkg::PQ_CAPACITY,
   parameter int CNT_W = $clog2(PQ_CAPACITY + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  pq_pkg::kv_t      s_kv,
   input  logic             s_last,
   output logic             m_valid,
   input  logic             m_ready,
   output pq_pkg::kv_t      m_kv,
   output logic             m_last,
   output logic             pq_enq,
   output logic             pq_deq,
   output pq_pkg::kv_t      pq_kvi,
   input  pq_pkg::kv_t      pq_kvo,
   input  logic             pq_full,
   input  logic             pq_empty,
   input  logic             pq_busy,
   output logic [CNT_W-1:0] batch_cnt,
   output logic             ovf,
   output logic             err
);
   typedef enum logic {FILL, DRAIN} state_t;
   state_t state, state_n;
   logic [CNT_W-1:0] remaining, cnt_nx;
   logic hs, load, underrun, at_cap, done, fill_end;
   always_comb begin
      s_ready  = rst && state == FILL && !pq_full && !pq_busy;
      hs       = s_valid && s_ready;
      load     = rst && state == DRAIN && (!m_valid || m_ready) && remaining != '0 && !pq_empty && !pq_busy;
      // an empty PQ while pairs are still owed means the PQ lost items; end the batch
      underrun = state == DRAIN && remaining != '0 && pq_empty;
      cnt_nx   = batch_cnt + CNT_W'(1);
      at_cap   = cnt_nx == CNT_W'(PQ_CAPACITY);
      fill_end = hs && (s_last || at_cap);
      done     = m_valid && m_ready && m_last;
      state_n  = (state == FILL) ? (fill_end ? DRAIN : FILL) : ((underrun || done) ? FILL : DRAIN);
      pq_enq   = hs;
      pq_deq   = load;
      pq_kvi   = s_kv;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= FILL;
         batch_cnt <= '0;
         remaining <= '0;
         m_valid   <= 1'b0;
         m_last    <= 1'b0;
         m_kv      <= '0;
         ovf       <= 1'b0;
         err       <= 1'b0;
      end else begin
         state <= state_n;
         if (hs) batch_cnt <= cnt_nx;
         if (fill_end) remaining <= cnt_nx;
         if (hs && at_cap && !s_last) ovf <= 1'b1;
         if (load) begin
            m_kv      <= pq_kvo;
            m_valid   <= 1'b1;
            m_last    <= remaining == CNT_W'(1);
            remaining <= remaining - CNT_W'(1);
         end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
         end
         if (underrun) begin
            err       <= 1'b1;
            remaining <= '0;
            batch_cnt <= '0;
         end
         if (done) batch_cnt <= '0;
      end
   end
endmodule

// File: tb/tb_pq_sort_host.sv
// tb_pq_sort_host: randomized scoreboard bench with a behavioural max-PQ attached
module tb_pq_sort_host;
   import pq_pkg::*;
   localparam int CAP = pq_pkg::PQ_CAPACITY;
   localparam int CW = $clog2(CAP + 1);
   typedef struct packed {kv_t kv; logic last;} exp_t;
   logic clk = 0, rst = 0;
   logic s_valid = 0, s_ready, s_last = 0;
   kv_t s_kv = '0;
   logic m_valid, m_ready = 1, m_last;
   kv_t m_kv;
   logic pq_enq, pq_deq;
   kv_t pq_kvi, pq_kvo;
   logic pq_full, pq_empty, pq_busy = 0;
   logic [CW-1:0] batch_cnt;
   logic ovf, err;
   int checks = 0, failures = 0;
   int enq_n = 0, deq_n = 0;
   logic busy_mode = 0, rnd_rdy = 0;
   bit rdy_pat[$];
   exp_t exp_q[$];
   kv_t batch[$];
   int keys_q[$];
   kv_t mem [CAP];
   int cnt = 0;
   always #5 clk = ~clk;
   pq_sort_host dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_kv(s_kv), .s_last(s_last),
      .m_valid(m_valid), .m_ready(m_ready), .m_kv(m_kv), .m_last(m_last),
      .pq_enq(pq_enq), .pq_deq(pq_deq), .pq_kvi(pq_kvi), .pq_kvo(pq_kvo),
      .pq_full(pq_full), .pq_empty(pq_empty), .pq_busy(pq_busy),
      .batch_cnt(batch_cnt), .ovf(ovf), .err(err)
   );
   // behavioural max-PQ: kept sorted by descending key, equal keys in arrival order
   assign pq_kvo = mem[0];
   assign pq_empty = cnt == 0;
   assign pq_full = cnt == CAP;
   always @(posedge clk) begin
      kv_t nm [CAP];
      int nc;
      int p;
      nm = mem;
      nc = cnt;
      if (!rst) nc = 0;
      else begin
         if (pq_deq && nc > 0) begin
            for (int i = 0; i < CAP - 1; i++) nm[i] = nm[i+1];
            nc--;
            deq_n++;
         end
         if (pq_enq && nc < CAP) begin
            p = nc;
            for (int i = nc - 1; i >= 0; i--) if (nm[i].key < pq_kvi.key) p = i;
            for (int i = CAP - 1; i > 0; i--) if (i > p) nm[i] = nm[i-1];
            nm[p] = pq_kvi;
            nc++;
            enq_n++;
         end
      end
      mem <= nm;
      cnt <= nc;
      pq_busy <= rst && busy_mode ? !pq_busy : 1'b0;
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask
   // reference: emit the batch highest key first, first-arrived first among equal keys
   task automatic push_expected();
      kv_t b[$];
      int mi;
      b = batch;
      batch.delete();
      while (b.size() > 0) begin
         mi = 0;
         for (int i = 1; i < b.size(); i++) if (b[i].key > b[mi].key) mi = i;
         exp_q.push_back('{kv: b[mi], last: b.size() == 1});
         b.delete(mi);
      end
   endtask
   task automatic send(input int n, input bit with_last);
      int t;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         s_valid = 1;
         s_kv.key = keys_q.size() > 0 ? 8'(keys_q.pop_front()) : 8'($urandom_range(0, 255));
         s_kv.val = 8'($urandom_range(0, 255));
         s_last = with_last && k == n - 1;
         #2;
         t = 0;
         while (!s_ready && t < 200) begin
            @(negedge clk);
            #2;
            t++;
         end
         if (t >= 200) begin
            chk("s_ready_timeout", 0, 1);
            s_valid = 0;
            return;
         end
         batch.push_back(s_kv);
         if (s_last || batch.size() == CAP) push_expected();
         @(posedge clk);
      end
      @(negedge clk);
      s_valid = 0;
      s_last = 0;
   endtask
   task automatic wait_idle();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || m_valid) && t < 600) begin
         @(negedge clk);
         t++;
      end
      if (t >= 600) chk("drain_timeout", exp_q.size(), 0);
      @(negedge clk);
      #2;
   endtask
   logic held_v = 0;
   kv_t held_kv;
   logic held_last;
   exp_t e;
   always @(negedge clk) begin
      #1;
      if (rdy_pat.size() > 0) begin
         if (m_valid) m_ready = rdy_pat.pop_front();
      end else m_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (rst) begin
         if (pq_enq || pq_deq) begin
            checks++;
            if (pq_busy || (pq_enq && pq_deq) || (pq_deq && m_valid && !m_ready)) begin
               failures++;
               $display("FAIL pq_cmd enq=%b deq=%b busy=%b m_valid=%b m_ready=%b", pq_enq, pq_deq, pq_busy, m_valid, m_ready);
            end
         end
         if (held_v && m_valid) chk("stall_hold", {m_kv, m_last}, {held_kv, held_last});
         held_v = m_valid && !m_ready;
         held_kv = m_kv;
         held_last = m_last;
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) chk("extra_beat", {m_kv, m_last}, 0);
            else begin
               e = exp_q.pop_front();
               chk("out_kv", m_kv, e.kv);
               chk("out_last", m_last, e.last);
            end
         end
      end else held_v = 0;
   end
   initial begin
      int e0, d0, t;
      repeat (3) @(negedge clk);
      chk("rst_s_ready", s_ready, 0);
      rst = 1;
      #2;
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_m_kv", m_kv, 0);
      chk("rst_batch_cnt", batch_cnt, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_err", err, 0);
      chk("rst_s_ready_fill", s_ready, 1);
      e0 = enq_n; d0 = deq_n;
      keys_q = '{5, 1, 9, 3};
      send(4, 1);
      #2;
      chk("b1_batch_cnt", batch_cnt, 4);
      wait_idle();
      chk("b1_enq", enq_n - e0, 4);
      chk("b1_deq", deq_n - d0, 4);
      chk("b1_batch_cnt_end", batch_cnt, 0);
      e0 = enq_n; d0 = deq_n;
      keys_q = '{7};
      send(1, 1);
      wait_idle();
      chk("b2_enq", enq_n - e0, 1);
      chk("b2_deq", deq_n - d0, 1);
      chk("b2_fill", s_ready, 1);
      rdy_pat = '{1, 0, 0, 1, 1};
      send(3, 1);
      wait_idle();
      busy_mode = 1;
      e0 = enq_n;
      send(6, 1);
      wait_idle();
      chk("busy_enq", enq_n - e0, 6);
      busy_mode = 0;
      rnd_rdy = 1;
      for (int b = 0; b < 4; b++) begin
         send($urandom_range(1, CAP - 1), 1);
         wait_idle();
      end
      rnd_rdy = 0;
      chk("pre_ovf", ovf, 0);
      send(CAP, 0);
      wait_idle();
      chk("cap_ovf", ovf, 1);
      send(3, 1);
      wait_idle();
      chk("post_ovf", ovf, 1);
      chk("post_err", err, 0);
      send(6, 1);
      t = 0;
      while (!m_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("mid_drain_valid", m_valid, 1);
      @(negedge clk);
      rst = 0;
      exp_q.delete();
      batch.delete();
      @(negedge clk);
      rst = 1;
      #2;
      chk("mr_m_valid", m_valid, 0);
      chk("mr_fill", s_ready, 1);
      chk("mr_batch_cnt", batch_cnt, 0);
      chk("mr_ovf", ovf, 0);
      send(2, 1);
      wait_idle();
      chk("mr_err", err, 0);
      chk("mr_batch_end", batch_cnt, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
